// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcodes, writeback selects and execute control words.
package lc3_pkg;

  localparam int LC3_DATA_W = 16;

  // Opcodes taken from instruction bits [15:12]
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // Writeback mux selects; 2'b11 is never produced
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  // Execute control word, MSB first as it appears on E_Control
  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_ctrl_t;

  // Execute control constants per instruction class
  localparam e_ctrl_t E_NONE    = 6'b000000;
  localparam e_ctrl_t E_ADD_REG = 6'b000001;
  localparam e_ctrl_t E_ADD_IMM = 6'b000000;
  localparam e_ctrl_t E_AND_REG = 6'b010001;
  localparam e_ctrl_t E_AND_IMM = 6'b010000;
  localparam e_ctrl_t E_NOT     = 6'b100000;
  localparam e_ctrl_t E_PC_OFF9 = 6'b000110;
  localparam e_ctrl_t E_BASE_O6 = 6'b001000;
  localparam e_ctrl_t E_BASE_Z  = 6'b001100;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational control decode: opcode plus the immediate flag (IR[5]) to
// execute, writeback and memory control words.
module lc3_decode_ctrl
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm_flag,
  output logic [5:0] e_control,
  output logic [1:0] w_control,
  output logic       mem_control
);

  e_ctrl_t e_word;

  // Decode table; unsupported opcodes (JSR, RTI, reserved, TRAP) fall to all-zero
  always_comb begin
    e_word      = E_NONE;
    w_control   = WB_ALU;
    mem_control = 1'b0;
    case (opcode)
      OP_ADD: e_word = imm_flag ? E_ADD_IMM : E_ADD_REG;
      OP_AND: e_word = imm_flag ? E_AND_IMM : E_AND_REG;
      OP_NOT: e_word = E_NOT;
      OP_BR,
      OP_ST:  e_word = E_PC_OFF9;
      OP_LD: begin
        e_word    = E_PC_OFF9;
        w_control = WB_MEM;
      end
      OP_LDI: begin
        e_word      = E_PC_OFF9;
        w_control   = WB_MEM;
        mem_control = 1'b1;
      end
      OP_STI: begin
        e_word      = E_PC_OFF9;
        mem_control = 1'b1;
      end
      OP_LEA: begin
        e_word    = E_PC_OFF9;
        w_control = WB_PC;
      end
      OP_LDR: begin
        e_word    = E_BASE_O6;
        w_control = WB_MEM;
      end
      OP_STR: e_word = E_BASE_O6;
      OP_JMP: e_word = E_BASE_Z;
      default: begin
        e_word      = E_NONE;
        w_control   = WB_ALU;
        mem_control = 1'b0;
      end
    endcase
  end

  assign e_control = e_word;

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: registers the fetched instruction and next-PC and the
// control words decoded from that same instruction, one clock of latency.
//
// Load protocol: enable_decode is a plain load strobe with no back-pressure.
// Every rising edge with enable_decode=1 (and reset=0) accepts dout/npc_in as a
// new instruction; with enable_decode=0 all outputs hold. Reset wins over load.
module lc3_decode_stage
  import lc3_pkg::*;
#(
  parameter int DATA_W = LC3_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_decode,
  input  logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] npc_in,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] npc_out,
  output logic [5:0]        E_Control,
  output logic [1:0]        W_Control,
  output logic              Mem_Control
);

  logic [5:0] e_next;
  logic [1:0] w_next;
  logic       m_next;

  // Decode the incoming word, not the held IR, so controls align with IR
  lc3_decode_ctrl u_ctrl (
    .opcode      (dout[15:12]),
    .imm_flag    (dout[5]),
    .e_control   (e_next),
    .w_control   (w_next),
    .mem_control (m_next)
  );

  // Pipeline register: synchronous reset, load on enable, otherwise hold
  always_ff @(posedge clock) begin
    if (reset) begin
      IR          <= '0;
      npc_out     <= '0;
      E_Control   <= '0;
      W_Control   <= '0;
      Mem_Control <= 1'b0;
    end else if (enable_decode) begin
      IR          <= dout;
      npc_out     <= npc_in;
      E_Control   <= e_next;
      W_Control   <= w_next;
      Mem_Control <= m_next;
    end
  end

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Bench for lc3_decode_stage: directed plan with literal expectations plus
// randomized traffic scored every cycle against a table-driven model.
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  logic [40:0] exp_q[$];

  lc3_decode_stage dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    reset         = 1'b1;
    enable_decode = 1'b1;
    dout          = 16'h1283;
    npc_in        = 16'h0000;
  end

  // ---------------- reference model ----------------
  // Control values per opcode straight from the instruction-set table.
  logic [5:0] e_tab [16];
  logic [1:0] w_tab [16];
  logic       m_tab [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      e_tab[i] = 6'd0; w_tab[i] = 2'd0; m_tab[i] = 1'b0;
    end
    e_tab[4'h1] = 6'b000001;  // ADD register form; imm form clears op2select
    e_tab[4'h5] = 6'b010001;  // AND register form
    e_tab[4'h9] = 6'b100000;  // NOT
    e_tab[4'h0] = 6'b000110;  // BR
    e_tab[4'h2] = 6'b000110; w_tab[4'h2] = 2'd1;                     // LD
    e_tab[4'hA] = 6'b000110; w_tab[4'hA] = 2'd1; m_tab[4'hA] = 1'b1; // LDI
    e_tab[4'hE] = 6'b000110; w_tab[4'hE] = 2'd2;                     // LEA
    e_tab[4'h3] = 6'b000110;                                         // ST
    e_tab[4'hB] = 6'b000110; m_tab[4'hB] = 1'b1;                     // STI
    e_tab[4'h6] = 6'b001000; w_tab[4'h6] = 2'd1;                     // LDR
    e_tab[4'h7] = 6'b001000;                                         // STR
    e_tab[4'hC] = 6'b001100;                                         // JMP
  end

  function automatic logic [40:0] model_load(input logic [15:0] instr, input logic [15:0] npc);
    int op;
    logic [5:0] e;
    op = int'(instr[15:12]);
    e  = e_tab[op];
    if ((op == 1 || op == 5) && instr[5]) e = e - 6'd1;  // immediate: op2select = 0
    return {instr, npc, e, w_tab[op], m_tab[op]};
  endfunction

  logic [40:0] model_state = '0;

  // Model advances on each edge from the inputs driven before it
  always @(posedge clock) begin
    if (reset)              model_state = '0;
    else if (enable_decode) model_state = model_load(dout, npc_in);
    exp_q.push_back(model_state);
  end

  // ---------------- scoreboard compare ----------------
  logic [40:0] exp_v;
  always @(negedge clock) begin
    if (!done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
      end else begin
        exp_v = exp_q.pop_front();
        if ({IR, npc_out, E_Control, W_Control, Mem_Control} !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_compare @%0t: got IR=%h npc=%h E=%b W=%0d M=%b, need IR=%h npc=%h E=%b W=%0d M=%b",
                   $time, IR, npc_out, E_Control, W_Control, Mem_Control,
                   exp_v[40:25], exp_v[24:9], exp_v[8:3], exp_v[2:1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input logic rst, input logic en, input logic [15:0] d, input logic [15:0] n);
    @(negedge clock);
    #1;
    reset = rst; enable_decode = en; dout = d; npc_in = n;
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                           input logic [5:0] e, input logic [1:0] w, input logic m);
    check({tag, "_ir"},  IR, ir);
    check({tag, "_npc"}, npc_out, npc);
    check({tag, "_e"},   {10'd0, E_Control}, {10'd0, e});
    check({tag, "_w"},   {14'd0, W_Control}, {14'd0, w});
    check({tag, "_m"},   {15'd0, Mem_Control}, {15'd0, m});
  endtask

  // Time limit: keeps the run bounded even if the clock stalls
  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- directed plan then random traffic ----------------
  initial begin
    // Reset held two edges with a valid load presented
    settle(); check_all("reset1", 16'h0, 16'h0, 6'b0, 2'd0, 1'b0);
    settle(); check_all("reset2", 16'h0, 16'h0, 6'b0, 2'd0, 1'b0);

    // First load on the first edge after reset drops
    apply(0, 1, 16'h1283, 16'h3001); settle();
    check_all("add_reg", 16'h1283, 16'h3001, 6'b000001, 2'd0, 1'b0);
    apply(0, 1, 16'h12A5, 16'h3002); settle();
    check_all("add_imm", 16'h12A5, 16'h3002, 6'b000000, 2'd0, 1'b0);

    apply(0, 1, 16'hA5FF, 16'h3003); settle();
    check_all("ldi", 16'hA5FF, 16'h3003, 6'b000110, 2'd1, 1'b1);
    apply(0, 1, 16'hB3F0, 16'h3004); settle();
    check_all("sti", 16'hB3F0, 16'h3004, 6'b000110, 2'd0, 1'b1);

    apply(0, 1, 16'hE405, 16'h3005); settle();
    check_all("lea", 16'hE405, 16'h3005, 6'b000110, 2'd2, 1'b0);
    apply(0, 1, 16'h6283, 16'h3006); settle();
    check_all("ldr", 16'h6283, 16'h3006, 6'b001000, 2'd1, 1'b0);
    apply(0, 1, 16'hC1C0, 16'h3007); settle();
    check_all("jmp", 16'hC1C0, 16'h3007, 6'b001100, 2'd0, 1'b0);

    // Hold: enable low while inputs churn
    apply(0, 1, 16'h5A7F, 16'h4000); settle();
    check_all("and_imm", 16'h5A7F, 16'h4000, 6'b010000, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 16'($urandom), 16'($urandom)); settle();
      check_all("hold", 16'h5A7F, 16'h4000, 6'b010000, 2'd0, 1'b0);
    end

    // Reset coincident with enable wins
    apply(1, 1, 16'h9FFF, 16'h5000); settle();
    check_all("midreset", 16'h0, 16'h0, 6'b0, 2'd0, 1'b0);

    // Unsupported opcode still captures IR/npc, controls zero
    apply(0, 1, 16'hF025, 16'h5001); settle();
    check_all("trap", 16'hF025, 16'h5001, 6'b0, 2'd0, 1'b0);

    // Randomized traffic, checked every cycle by the scoreboard
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            16'($urandom), 16'($urandom));
    end

    @(negedge clock);
    @(negedge clock);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
